// File: rtl/harmonic_dds_gen.sv
// harmonic_dds_gen: DDS source built from a fundamental plus harmonics 2..5.
// One sine LUT and one multiplier are shared across the five harmonics
// inside each SAMPLE_DIV-cycle sample period. The result is written as
// offset binary for a DAC. Configuration is double-buffered so that it
// only ever changes on a sample boundary.
module harmonic_dds_gen #(
  parameter int PHASE_W    = 24,
  parameter int AMP_W      = 8,
  parameter int DAC_W      = 10,
  parameter int SAMPLE_DIV = 10,
  parameter int SCALE_SH   = 6
) (
  input  logic                 clk_1m,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [PHASE_W-1:0]   cfg_fword,
  input  logic [5*AMP_W-1:0]   cfg_amp,
  output logic [DAC_W-1:0]     dac_data,
  output logic                 dac_valid,
  output logic                 cycle_start,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam int PROD_W = 8 + AMP_W;
  localparam int ACC_W  = PROD_W + 4;
  localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (DAC_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] S_MIN = ACC_W'(-(1 << (DAC_W - 1)));
  localparam logic [DAC_W-1:0] DAC_MID = {1'b1, {(DAC_W-1){1'b0}}};

  logic [CNT_W-1:0]         cnt;
  logic                     at_start, at_out, acc_en;
  logic                     pending;
  logic [PHASE_W-1:0]       fword_sh, fword;
  logic [5*AMP_W-1:0]       amp_sh, amp;
  logic [PHASE_W-1:0]       phase_acc, harm_ph;
  logic [7:0]               lut_addr;
  logic signed [7:0]        lut_q;
  logic [AMP_W-1:0]         amp_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc, scaled;
  logic [DAC_W-1:0]         clamped, dac_next;
  logic                     wrap_flag, start_flag;

  // Quarter-wave magnitude table: round(127*sin(2*pi*i/256)) for i = 0..64.
  function automatic logic [6:0] quarter_sine(input logic [6:0] i);
    case (i)
      7'd0:  return 7'd0;   7'd1:  return 7'd3;   7'd2:  return 7'd6;   7'd3:  return 7'd9;   7'd4:  return 7'd12;
      7'd5:  return 7'd16;  7'd6:  return 7'd19;  7'd7:  return 7'd22;  7'd8:  return 7'd25;  7'd9:  return 7'd28;
      7'd10: return 7'd31;  7'd11: return 7'd34;  7'd12: return 7'd37;  7'd13: return 7'd40;  7'd14: return 7'd43;
      7'd15: return 7'd46;  7'd16: return 7'd49;  7'd17: return 7'd51;  7'd18: return 7'd54;  7'd19: return 7'd57;
      7'd20: return 7'd60;  7'd21: return 7'd63;  7'd22: return 7'd65;  7'd23: return 7'd68;  7'd24: return 7'd71;
      7'd25: return 7'd73;  7'd26: return 7'd76;  7'd27: return 7'd78;  7'd28: return 7'd81;  7'd29: return 7'd83;
      7'd30: return 7'd85;  7'd31: return 7'd88;  7'd32: return 7'd90;  7'd33: return 7'd92;  7'd34: return 7'd94;
      7'd35: return 7'd96;  7'd36: return 7'd98;  7'd37: return 7'd100; 7'd38: return 7'd102; 7'd39: return 7'd104;
      7'd40: return 7'd106; 7'd41: return 7'd107; 7'd42: return 7'd109; 7'd43: return 7'd111; 7'd44: return 7'd112;
      7'd45: return 7'd113; 7'd46: return 7'd115; 7'd47: return 7'd116; 7'd48: return 7'd117; 7'd49: return 7'd118;
      7'd50: return 7'd120; 7'd51: return 7'd121; 7'd52: return 7'd122; 7'd53: return 7'd122; 7'd54: return 7'd123;
      7'd55: return 7'd124; 7'd56: return 7'd125; 7'd57: return 7'd125; 7'd58: return 7'd126; 7'd59: return 7'd126;
      7'd60: return 7'd126; 7'd61: return 7'd127; 7'd62: return 7'd127; 7'd63: return 7'd127; 7'd64: return 7'd127;
      default: return 7'd0;
    endcase
  endfunction

  // Full 256-point signed sine built from the quarter table by symmetry.
  function automatic logic signed [7:0] sine_lut(input logic [7:0] a);
    logic [6:0] idx;
    logic [7:0] mag;
    idx = a[6] ? 7'(7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
    mag = {1'b0, quarter_sine(idx)};
    return a[7] ? -$signed(mag) : $signed(mag);
  endfunction

  assign at_start  = (cnt == '0);
  assign at_out    = (cnt == CNT_W'(7));
  assign acc_en    = (cnt >= CNT_W'(2)) && (cnt <= CNT_W'(6));
  assign cfg_ready = !pending;

  // Free-running slot counter that paces one output sample per wrap.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n)                             cnt <= '0;
    else if (cnt == CNT_W'(SAMPLE_DIV - 1)) cnt <= '0;
    else                                    cnt <= cnt + CNT_W'(1);
  end

  // Shadow capture on handshake; promotion to active only on a sample boundary.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      pending  <= 1'b0;
      fword_sh <= '0;
      amp_sh   <= '0;
      fword    <= '0;
      amp      <= '0;
    end else begin
      if (cfg_valid && cfg_ready) begin
        fword_sh <= cfg_fword;
        amp_sh   <= cfg_amp;
      end
      if (at_start && pending) begin
        fword   <= fword_sh;
        amp     <= amp_sh;
        pending <= 1'b0;
      end else if (cfg_valid && cfg_ready) begin
        pending <= 1'b1;
      end
    end
  end

  // Harmonic phase for slot k is k*phase (mod 2^PHASE_W); its top 8 bits address the LUT.
  always_comb begin
    harm_ph  = phase_acc * PHASE_W'(cnt);
    lut_addr = 8'(harm_ph >> (PHASE_W - 8));
  end

  // Registered LUT read: the value looked up in slot k is consumed in slot k+1.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) lut_q <= '0;
    else        lut_q <= sine_lut(lut_addr);
  end

  // Pick the amplitude that matches the sine sample currently held in lut_q.
  always_comb begin
    amp_sel = '0;
    for (int k = 0; k < 5; k++)
      if (cnt == CNT_W'(k + 2)) amp_sel = amp[k*AMP_W +: AMP_W];
    prod = PROD_W'(lut_q) * $signed({{(PROD_W-AMP_W){1'b0}}, amp_sel});
  end

  // Harmonic sum, cleared at the start of every sample.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n)        acc <= '0;
    else if (at_start) acc <= '0;
    else if (acc_en)   acc <= acc + ACC_W'(prod);
  end

  // Scale with floor shift, saturate to DAC range and convert to offset binary.
  always_comb begin
    scaled = acc >>> SCALE_SH;
    if (scaled > S_MAX)      clamped = {1'b0, {(DAC_W-1){1'b1}}};
    else if (scaled < S_MIN) clamped = {1'b1, {(DAC_W-1){1'b0}}};
    else                     clamped = DAC_W'(scaled);
    dac_next = {~clamped[DAC_W-1], clamped[DAC_W-2:0]};
  end

  // Sample-boundary control: enable sampling, phase advance and output update.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      phase_acc  <= '0;
      busy       <= 1'b0;
      wrap_flag  <= 1'b0;
      start_flag <= 1'b0;
      dac_data   <= DAC_MID;
    end else begin
      if (at_start) begin
        if (enable) begin
          start_flag <= (phase_acc == '0) && (wrap_flag || !busy);
          busy       <= 1'b1;
        end else begin
          start_flag <= 1'b0;
          busy       <= 1'b0;
          wrap_flag  <= 1'b0;
          phase_acc  <= '0;
        end
      end
      if (at_out) begin
        if (busy) begin
          dac_data               <= dac_next;
          {wrap_flag, phase_acc} <= {1'b0, phase_acc} + {1'b0, fword};
        end else begin
          dac_data <= DAC_MID;
        end
      end
    end
  end

  // One-cycle strobes that accompany the freshly written sample.
  always_ff @(posedge clk_1m or negedge rst_n) begin
    if (!rst_n) begin
      dac_valid   <= 1'b0;
      cycle_start <= 1'b0;
    end else begin
      dac_valid   <= at_out;
      cycle_start <= at_out && busy && start_flag;
    end
  end

endmodule

// File: tb/tb_harmonic_dds_gen.sv
// tb_harmonic_dds_gen: directed and randomized bench for harmonic_dds_gen
// with a sample-level reference model built from real-valued sine math.
`timescale 1ns/1ps
module tb_harmonic_dds_gen;

  logic        clk_1m = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [23:0] cfg_fword = '0;
  logic [39:0] cfg_amp = '0;
  logic [9:0]  dac_data;
  logic        dac_valid, cycle_start, busy;

  harmonic_dds_gen dut (
    .clk_1m(clk_1m), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fword(cfg_fword), .cfg_amp(cfg_amp),
    .dac_data(dac_data), .dac_valid(dac_valid),
    .cycle_start(cycle_start), .busy(busy)
  );

  always #500 clk_1m = ~clk_1m;

  int checks_total = 0;
  int checks_passed = 0;
  int sin_tab[256];

  int     m_slot, m_dac, m_sample;
  bit     m_pending, m_busy, m_wrapped, m_start, m_valid, m_cs;
  longint m_phase, m_fw, m_sh_fw;
  int     m_amp[5], m_sh_amp[5];
  int     seen_q[$];
  int     cs_q[$];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks_total++;
    if (observed == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
  endtask

  // Output code for one sample: sum of harmonics, floor-divide by 64, saturate, offset.
  function automatic int model_sample(longint phase);
    longint sum, p, q;
    sum = 0;
    for (int h = 1; h <= 5; h++) begin
      p = (longint'(h) * phase) % 64'sd16777216;
      sum += longint'(sin_tab[int'(p / 65536)]) * longint'(m_amp[h-1]);
    end
    q = sum / 64;
    if (sum < 0 && (sum % 64) != 0) q -= 1;
    if (q > 511) q = 511;
    if (q < -512) q = -512;
    return int'(q) + 512;
  endfunction

  function automatic void model_reset();
    m_slot = 0; m_dac = 512; m_sample = 512;
    m_pending = 0; m_busy = 0; m_wrapped = 0; m_start = 0; m_valid = 0; m_cs = 0;
    m_phase = 0; m_fw = 0; m_sh_fw = 0;
    for (int k = 0; k < 5; k++) begin m_amp[k] = 0; m_sh_amp[k] = 0; end
  endfunction

  // Advance the model across one clock edge using the currently driven inputs.
  function automatic void model_edge();
    bit accept;
    longint nxt;
    accept = cfg_valid && !m_pending;
    if (m_slot == 0) begin
      if (m_pending) begin
        m_fw = m_sh_fw;
        for (int k = 0; k < 5; k++) m_amp[k] = m_sh_amp[k];
        m_pending = 0;
      end
      if (enable) begin
        m_start  = (m_phase == 0) && (m_wrapped || !m_busy);
        m_sample = model_sample(m_phase);
        m_busy   = 1;
      end else begin
        m_phase = 0; m_wrapped = 0; m_busy = 0; m_start = 0; m_sample = 512;
      end
    end
    if (accept) begin
      m_sh_fw = longint'(cfg_fword);
      for (int k = 0; k < 5; k++) m_sh_amp[k] = int'(cfg_amp[k*8 +: 8]);
      m_pending = 1;
    end
    m_valid = (m_slot == 7);
    m_cs    = (m_slot == 7) && m_busy && m_start;
    if (m_slot == 7) begin
      m_dac = m_sample;
      if (m_busy) begin
        nxt       = m_phase + m_fw;
        m_wrapped = (nxt >= 64'sd16777216);
        m_phase   = nxt % 64'sd16777216;
      end
    end
    m_slot = (m_slot + 1) % 10;
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk_1m);
    #1;
    checkOutput("dac_data", int'(dac_data), m_dac);
    checkOutput("dac_valid", int'(dac_valid), int'(m_valid));
    checkOutput("cycle_start", int'(cycle_start), int'(m_cs));
    checkOutput("busy", int'(busy), int'(m_busy));
    checkOutput("cfg_ready", int'(cfg_ready), int'(!m_pending));
    if (dac_valid) begin
      seen_q.push_back(int'(dac_data));
      cs_q.push_back(int'(cycle_start));
    end
  endtask

  task automatic applyStimulus(input logic en, input logic cv, input logic [23:0] fw, input logic [39:0] am);
    enable = en; cfg_valid = cv; cfg_fword = fw; cfg_amp = am;
    step();
  endtask

  task automatic idle(input int n, input logic en);
    repeat (n) applyStimulus(en, 1'b0, cfg_fword, cfg_amp);
  endtask

  task automatic run_until_slot(input int s, input logic en);
    while (m_slot != s) applyStimulus(en, 1'b0, cfg_fword, cfg_amp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    #1;
    checkOutput("rst_dac_data", int'(dac_data), 512);
    checkOutput("rst_dac_valid", int'(dac_valid), 0);
    checkOutput("rst_cycle_start", int'(cycle_start), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_cfg_ready", int'(cfg_ready), 1);
    @(posedge clk_1m);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic run_seq(input string tag, input logic [23:0] fw, input logic [39:0] am,
                         input int exp_d[8], input int exp_c[8]);
    do_reset();
    applyStimulus(1'b0, 1'b1, fw, am);
    idle(19, 1'b0);
    seen_q.delete();
    cs_q.delete();
    idle(80, 1'b1);
    checkOutput({tag, "_count"}, seen_q.size(), 8);
    if (seen_q.size() >= 8)
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("%s_data%0d", tag, i), seen_q[i], exp_d[i]);
        checkOutput($sformatf("%s_cs%0d", tag, i), cs_q[i], exp_c[i]);
      end
  endtask

  initial begin
    #50000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cs_pat[8];
    int d_fund[8];
    int d_mid[8];
    int d_sat[8];
    logic [23:0] fw;
    logic [39:0] am;
    logic en;

    for (int i = 0; i < 256; i++)
      sin_tab[i] = int'(127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0));
    cs_pat = '{1, 0, 0, 0, 1, 0, 0, 0};
    d_fund = '{512, 1018, 512, 5, 512, 1018, 512, 5};
    d_mid  = '{512, 512, 512, 512, 512, 512, 512, 512};
    d_sat  = '{512, 1023, 512, 0, 512, 1023, 512, 0};

    #10;
    do_reset();
    seen_q.delete();
    idle(30, 1'b0);
    checkOutput("idle_pulses", seen_q.size(), 3);

    run_seq("fund", 24'd4194304, 40'h00_00_00_00_FF, d_fund, cs_pat);
    run_seq("h2only", 24'd4194304, 40'h00_00_00_FF_00, d_mid, cs_pat);
    run_seq("h1h5sat", 24'd4194304, 40'hFF_00_00_00_FF, d_sat, cs_pat);

    run_until_slot(3, 1'b1);
    applyStimulus(1'b1, 1'b1, 24'd2097152, 40'h00_00_40_00_80);
    checkOutput("cfg_ready_low", int'(cfg_ready), 0);
    run_until_slot(5, 1'b1);
    applyStimulus(1'b1, 1'b1, 24'd123, 40'hFF_FF_FF_FF_FF);
    run_until_slot(0, 1'b1);
    checkOutput("cfg_ready_held", int'(cfg_ready), 0);
    applyStimulus(1'b1, 1'b0, 24'd0, 40'h0);
    checkOutput("cfg_ready_back", int'(cfg_ready), 1);
    idle(40, 1'b1);

    run_until_slot(4, 1'b1);
    do_reset();
    seen_q.delete();
    cs_q.delete();
    idle(10, 1'b1);
    checkOutput("post_rst_pulses", seen_q.size(), 1);
    if (seen_q.size() >= 1) begin
      checkOutput("post_rst_data", seen_q[0], 512);
      checkOutput("post_rst_cs", cs_q[0], 1);
    end

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0:       fw = 24'($urandom);
        1:       fw = 24'($urandom_range(1, 15) << 20);
        2:       fw = 24'd0;
        default: fw = 24'($urandom_range(0, 255));
      endcase
      am = {8'($urandom), 32'($urandom)};
      en = ($urandom_range(0, 9) != 0);
      idle($urandom_range(0, 9), en);
      applyStimulus(en, 1'b1, fw, am);
      for (int c = 0; c < $urandom_range(10, 40); c++) begin
        if ($urandom_range(0, 7) == 0)
          applyStimulus(en, 1'b1, 24'($urandom), {8'($urandom), 32'($urandom)});
        else
          applyStimulus(en, 1'b0, cfg_fword, cfg_amp);
      end
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
